// File: rtl/main_mem_burst.sv
// Word-addressed burst RAM mapped at BASE_ADDR.
// Supports single and 4/8/16-word bursts with a configurable read latency.
// Misaligned, below-base and past-the-end commands are rejected with a
// one-cycle error pulse and never touch the array.
module main_mem_burst #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH_WORDS  = 262144,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h8002_0000,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wren,
    input  logic [1:0]            acc_size,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Number of READ_WAIT edges before the first beat is loaded.
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ_BURST
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_t                state_reg;
    logic [IDX_W-1:0]      ptr_reg;
    logic [3:0]            beat_reg;
    logic [3:0]            last_reg;
    logic [1:0]            wait_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  valid_reg;
    logic                  busy_reg;
    logic                  error_reg;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [ADDR_WIDTH:0]   end_idx;
    logic [IDX_W-1:0]      idx;
    logic [4:0]            burst_len;
    logic [3:0]            burst_last;
    logic                  cmd_bad;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;

    assign offset   = addr - BASE_ADDR;
    assign word_off = offset >> 2;
    assign idx      = word_off[IDX_W-1:0];
    // One bit wider than the address so idx+N cannot wrap back into range.
    assign end_idx  = {1'b0, word_off} + {{(ADDR_WIDTH - 4){1'b0}}, burst_len};
    assign cmd_bad  = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || (end_idx > DEPTH_EXT);

    // Decode the burst length and its final beat number.
    always_comb begin
        burst_len  = 5'd1;
        burst_last = 4'd0;
        case (acc_size)
            2'b01:   begin burst_len = 5'd4;  burst_last = 4'd3;  end
            2'b10:   begin burst_len = 5'd8;  burst_last = 4'd7;  end
            2'b11:   begin burst_len = 5'd16; burst_last = 4'd15; end
            default: begin burst_len = 5'd1;  burst_last = 4'd0;  end
        endcase
    end

    // Write port: beat 0 lands in the accepting cycle, later beats from ptr_reg.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr_reg;
        if (!reset) begin
            if (state_reg == ST_IDLE && enable && !cmd_bad && wren) begin
                mem_we    = 1'b1;
                mem_waddr = idx;
            end else if (state_reg == ST_WRITE) begin
                mem_we = 1'b1;
            end
        end
    end

    // Array storage; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= data_in;
        end
    end

    // Command FSM with registered read data and handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            beat_reg     <= 4'd0;
            last_reg     <= 4'd0;
            wait_reg     <= 2'd0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    valid_reg <= 1'b0;
                    if (enable) begin
                        if (cmd_bad) begin
                            error_reg <= 1'b1;
                        end else if (wren) begin
                            if (burst_len != 5'd1) begin
                                state_reg <= ST_WRITE;
                                busy_reg  <= 1'b1;
                                ptr_reg   <= idx + IDX_W'(1);
                                beat_reg  <= 4'd1;
                                last_reg  <= burst_last;
                            end
                        end else begin
                            busy_reg <= 1'b1;
                            beat_reg <= 4'd0;
                            last_reg <= burst_last;
                            if (READ_LATENCY == 1) begin
                                data_out_reg <= mem[idx];
                                valid_reg    <= 1'b1;
                                ptr_reg      <= idx + IDX_W'(1);
                                state_reg    <= ST_READ_BURST;
                            end else begin
                                ptr_reg   <= idx;
                                wait_reg  <= 2'd1;
                                state_reg <= ST_READ_WAIT;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (beat_reg == last_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        beat_reg <= beat_reg + 4'd1;
                        ptr_reg  <= ptr_reg + IDX_W'(1);
                    end
                end
                ST_READ_WAIT: begin
                    if (wait_reg == WAIT_LAST) begin
                        data_out_reg <= mem[ptr_reg];
                        valid_reg    <= 1'b1;
                        ptr_reg      <= ptr_reg + IDX_W'(1);
                        state_reg    <= ST_READ_BURST;
                    end else begin
                        wait_reg <= wait_reg + 2'd1;
                    end
                end
                ST_READ_BURST: begin
                    if (beat_reg == last_reg) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        data_out_reg <= mem[ptr_reg];
                        ptr_reg      <= ptr_reg + IDX_W'(1);
                        beat_reg     <= beat_reg + 4'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign data_out = data_out_reg;
    assign valid    = valid_reg;
    assign busy     = busy_reg;
    assign error    = error_reg;

endmodule
